truth_table_sweeper: RTL

- Upstream stimulus stage for the lab's combinational Boolean function blocks (3-input, 1-output, e.g. F = (A xnor B) | (A & C)).
- On a start pulse, drives every input combination 0..2^N_IN-1 in ascending order.
- Holds each combination for a programmable dwell time and samples the function output on the last dwell cycle.
- Assembles the results into a truth-table vector and signals completion with a one-cycle done pulse; feeds the LED/7-seg display stage.

---
 rtl/truth_table_sweeper_if.sv | 32 +++
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Stimulus/result bundle between the truth-table sweeper and its
//               control, function-under-test and display neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic                   abort;
    logic                   f_in;
    logic [N_IN-1:0]        abc;
    logic [N_IN-1:0]        idx;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   tt_out;
    logic                   tt_valid;

    // master is the sweeper itself; slave is everything around it
    modport master (
        input  start, abort, f_in,
        output abc, idx, busy, done, tt_out, tt_valid
    );

    modport slave (
        output start, abort, f_in,
        input  abc, idx, busy, done, tt_out, tt_valid
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks every input combination of a small Boolean function,
//               samples its output and assembles a truth-table vector.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_IN  = 3,
    parameter int DWELL = 4
) (
    input  wire                         clk,
    input  wire                         rst_n,
    truth_table_sweeper_if.master       bus
);
    localparam int c_N_COMB = 1 << N_IN;
    localparam int c_CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N_IN-1:0]    c_LAST       = {N_IN{1'b1}};
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N_IN-1:0]        r_abc;
    logic [N_IN-1:0]        r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic [c_N_COMB-1:0]    r_shadow;
    logic [c_N_COMB-1:0]    r_tt_out;
    logic                   r_tt_valid;
    logic [c_CNT_W-1:0]     r_dwell_cnt;

    logic [c_N_COMB-1:0]    w_shadow_next;
    logic                   w_sample;
    logic                   w_last;

    // Shadow with the current sample merged in, so the final sample reaches
    // tt_out on the same edge that enters DONE.
    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = bus.f_in;
    end

    assign w_sample = (r_dwell_cnt == c_DWELL_LAST);
    assign w_last   = (r_idx == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_abc       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_shadow    <= '0;
            r_tt_out    <= '0;
            r_tt_valid  <= 1'b0;
            r_dwell_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_abc  <= '0;
                    if (bus.start) begin
                        r_state     <= S_DRIVE;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_dwell_cnt <= '0;
                        r_shadow    <= '0;
                        r_tt_valid  <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    // abort wins over the final sample, leaving tt_out untouched
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abc   <= '0;
                    end else if (w_sample) begin
                        r_shadow    <= w_shadow_next;
                        r_dwell_cnt <= '0;
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_abc      <= '0;
                            r_tt_out   <= w_shadow_next;
                            r_tt_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_abc <= r_idx + 1'b1;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_abc   <= '0;
                end
            endcase
        end
    end

    assign bus.abc      = r_abc;
    assign bus.idx      = r_idx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.tt_out   = r_tt_out;
    assign bus.tt_valid = r_tt_valid;

endmodule
`default_nettype wire
